// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-rule engine.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    SCORED    = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;
  localparam int   SCORE_W = 4;

endpackage

// File: rtl/ball_bounce_ctrl_paddle_hit.sv
// Combinational test of whether a ball row falls on a paddle's vertical span.
module paddle_hit #(
  parameter int CWIDTH   = 9,
  parameter int PADDLE_H = 64
) (
  input  logic [CWIDTH:0] ball_y,
  input  logic [CWIDTH:0] paddle_y,
  output logic            hit
);

  localparam logic [CWIDTH+1:0] SPAN_M1 = (CWIDTH+2)'(PADDLE_H - 1);

  logic [CWIDTH+1:0] by_w;
  logic [CWIDTH+1:0] top_w;
  logic [CWIDTH+1:0] bot_w;

  // One extra bit keeps a paddle near the bottom edge from wrapping its span.
  assign by_w  = {1'b0, ball_y};
  assign top_w = {1'b0, paddle_y};
  assign bot_w = top_w + SPAN_M1;
  assign hit   = (by_w >= top_w) && (by_w <= bot_w);

endmodule

// File: rtl/ball_bounce_ctrl.sv
// Pong game-rule engine: bounces, paddle hits, misses, scoring and serve/game-over FSM.
module ball_bounce_ctrl
  import pong_pkg::*;
#(
  parameter int CWIDTH       = 9,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int PADDLE_H     = 64,
  parameter int L_PADDLE_X   = 16,
  parameter int R_PADDLE_X   = 623,
  parameter int SERVE_CYCLES = 1000,
  parameter int WIN_SCORE    = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [CWIDTH:0]     ball_x,
  input  logic [CWIDTH:0]     ball_y,
  input  logic [CWIDTH:0]     paddle_l_y,
  input  logic [CWIDTH:0]     paddle_r_y,
  output logic                dir_x,
  output logic                dir_y,
  output logic                ball_active,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic                game_over
);

  localparam int CNT_W = $clog2(SERVE_CYCLES + 1);

  localparam logic [CWIDTH:0]    XMAX_Q  = (CWIDTH+1)'(X_MAX);
  localparam logic [CWIDTH:0]    YMAX_Q  = (CWIDTH+1)'(Y_MAX);
  localparam logic [CWIDTH:0]    LPX_Q   = (CWIDTH+1)'(L_PADDLE_X);
  localparam logic [CWIDTH:0]    RPX_Q   = (CWIDTH+1)'(R_PADDLE_X);
  localparam logic [CNT_W-1:0]   SRV_END = CNT_W'(SERVE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_Q   = SCORE_W'(WIN_SCORE);

  game_state_t      state;
  logic [CNT_W-1:0] serve_cnt;
  logic             hit_l;
  logic             hit_r;
  logic             miss_l;
  logic             miss_r;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN_Q) ? WIN_Q : s + 1'b1;
  endfunction

  paddle_hit #(.CWIDTH(CWIDTH), .PADDLE_H(PADDLE_H)) u_hit_l (
    .ball_y   (ball_y),
    .paddle_y (paddle_l_y),
    .hit      (hit_l)
  );

  paddle_hit #(.CWIDTH(CWIDTH), .PADDLE_H(PADDLE_H)) u_hit_r (
    .ball_y   (ball_y),
    .paddle_y (paddle_r_y),
    .hit      (hit_r)
  );

  assign miss_l = (ball_x == '0)     && (dir_x == DIR_DEC);
  assign miss_r = (ball_x == XMAX_Q) && (dir_x == DIR_INC);

  assign ball_active = (state == PLAY);
  assign game_over   = (state == GAME_OVER);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      serve_cnt <= '0;
      dir_x     <= DIR_INC;
      dir_y     <= DIR_INC;
      score_l   <= '0;
      score_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SERVE;
            serve_cnt <= '0;
            score_l   <= '0;
            score_r   <= '0;
            dir_x     <= DIR_INC;
            dir_y     <= DIR_INC;
          end
        end
        SERVE: begin
          if (serve_cnt == SRV_END) begin
            serve_cnt <= '0;
            state     <= PLAY;
          end else begin
            serve_cnt <= serve_cnt + 1'b1;
          end
        end
        PLAY: begin
          // A miss overrides any wall bounce on the same cycle; dir_y stays put.
          if (miss_l) begin
            score_r <= sat_inc(score_r);
            dir_x   <= DIR_DEC;
            state   <= SCORED;
          end else if (miss_r) begin
            score_l <= sat_inc(score_l);
            dir_x   <= DIR_INC;
            state   <= SCORED;
          end else begin
            if (ball_y == '0 && dir_y == DIR_DEC)
              dir_y <= DIR_INC;
            else if (ball_y == YMAX_Q && dir_y == DIR_INC)
              dir_y <= DIR_DEC;
            if (ball_x == LPX_Q && dir_x == DIR_DEC && hit_l)
              dir_x <= DIR_INC;
            else if (ball_x == RPX_Q && dir_x == DIR_INC && hit_r)
              dir_x <= DIR_DEC;
          end
        end
        SCORED: begin
          state <= (score_l == WIN_Q || score_r == WIN_Q) ? GAME_OVER : SERVE;
        end
        GAME_OVER: begin
          if (start) begin
            state     <= SERVE;
            serve_cnt <= '0;
            score_l   <= '0;
            score_r   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
